// File: rtl/fpu_arbiter.sv
// Round-robin arbiter that shares one pipelined FPU between NUM_REQ requesters.
// It registers the granted operation, tags it with the requester ID and returns results on a shared bus.
module fpu_arbiter #(
    parameter int NUM_REQ        = 4,
    parameter int PIPELINE_DEPTH = 3,
    parameter int ID_W           = $clog2(NUM_REQ)
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic [NUM_REQ-1:0]     req_valid_i,
    output logic [NUM_REQ-1:0]     req_ready_o,
    input  logic [NUM_REQ*16-1:0]  req_opA_i,
    input  logic [NUM_REQ*16-1:0]  req_opB_i,
    input  logic [NUM_REQ*2-1:0]   req_op_i,
    output logic [15:0]            fpu_opA_o,
    output logic [15:0]            fpu_opB_o,
    output logic [1:0]             fpu_op_o,
    output logic [1:0]             fpu_status_o,
    input  logic [15:0]            fpu_result_i,
    input  logic [1:0]             fpu_status_i,
    output logic                   rsp_valid_o,
    output logic [ID_W-1:0]        rsp_id_o,
    output logic [15:0]            rsp_result_o,
    input  logic                   drain_i,
    output logic                   idle_o,
    output logic                   err_o
);

    // state | meaning
    // RUN   | granting one operation per cycle
    // DRAIN | no grants, waiting for the issue stage and tag pipe to empty
    // IDLE  | no grants, nothing in flight
    typedef enum logic [1:0] {ST_RUN, ST_DRAIN, ST_IDLE} state_e;

    localparam int CNT_W = $clog2(PIPELINE_DEPTH + 2);
    localparam logic [CNT_W-1:0] CHK_START = CNT_W'(PIPELINE_DEPTH + 1);

    state_e                                 state_q, state_d;
    logic [ID_W-1:0]                        rr_ptr_q, rr_ptr_d;
    logic [15:0]                            opa_q, opa_d, opb_q, opb_d;
    logic [1:0]                             op_q, op_d, status_q, status_d;
    logic [ID_W-1:0]                        issue_id_q, issue_id_d;
    logic [PIPELINE_DEPTH-1:0]              tag_vld_q, tag_vld_d;
    logic [PIPELINE_DEPTH-1:0][ID_W-1:0]    tag_id_q, tag_id_d;
    logic [CNT_W-1:0]                       cnt_q, cnt_d;
    logic                                   err_q, err_d;

    logic                                   grant_en, grant_vld, inflight, chk_en;
    logic [ID_W-1:0]                        grant_id, cand_id;
    int                                     cand;

    always_comb begin
        grant_en    = (state_q == ST_RUN) && !drain_i;
        grant_vld   = 1'b0;
        grant_id    = '0;
        cand        = 0;
        cand_id     = '0;
        req_ready_o = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            cand = int'(rr_ptr_q) + i;
            if (cand >= NUM_REQ) cand = cand - NUM_REQ;
            cand_id = ID_W'(cand);
            if (grant_en && !grant_vld && req_valid_i[cand_id]) begin
                grant_vld = 1'b1;
                grant_id  = cand_id;
            end
        end
        if (grant_vld) req_ready_o[grant_id] = 1'b1;
    end

    always_comb begin
        rr_ptr_d   = rr_ptr_q;
        opa_d      = opa_q;
        opb_d      = opb_q;
        op_d       = op_q;
        issue_id_d = issue_id_q;
        status_d   = 2'b00;
        if (grant_vld) begin
            rr_ptr_d   = (int'(grant_id) == NUM_REQ - 1) ? '0 : grant_id + 1'b1;
            opa_d      = req_opA_i[int'(grant_id)*16 +: 16];
            opb_d      = req_opB_i[int'(grant_id)*16 +: 16];
            op_d       = req_op_i[int'(grant_id)*2 +: 2];
            issue_id_d = grant_id;
            status_d   = 2'b01;
        end
    end

    // The issue register is the stage ahead of the tag pipe, lining the tail up with the FPU output.
    always_comb begin
        tag_vld_d    = '0;
        tag_id_d     = '0;
        tag_vld_d[0] = (status_q == 2'b01);
        tag_id_d[0]  = issue_id_q;
        for (int i = 1; i < PIPELINE_DEPTH; i++) begin
            tag_vld_d[i] = tag_vld_q[i-1];
            tag_id_d[i]  = tag_id_q[i-1];
        end
    end

    always_comb begin
        inflight = (status_q != 2'b00) || (|tag_vld_q);
        state_d  = state_q;
        case (state_q)
            ST_RUN:   if (drain_i)   state_d = ST_DRAIN;
            ST_DRAIN: if (!inflight) state_d = ST_IDLE;
            ST_IDLE:  if (!drain_i)  state_d = ST_RUN;
            default:                 state_d = ST_RUN;
        endcase
    end

    always_comb begin
        chk_en = (cnt_q == CHK_START);
        cnt_d  = chk_en ? cnt_q : cnt_q + 1'b1;
        err_d  = err_q | (chk_en && (tag_vld_q[PIPELINE_DEPTH-1] != (fpu_status_i != 2'b00)));
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q    <= ST_RUN;
            rr_ptr_q   <= '0;
            opa_q      <= '0;
            opb_q      <= '0;
            op_q       <= '0;
            status_q   <= 2'b00;
            issue_id_q <= '0;
            tag_vld_q  <= '0;
            tag_id_q   <= '0;
            cnt_q      <= '0;
            err_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            rr_ptr_q   <= rr_ptr_d;
            opa_q      <= opa_d;
            opb_q      <= opb_d;
            op_q       <= op_d;
            status_q   <= status_d;
            issue_id_q <= issue_id_d;
            tag_vld_q  <= tag_vld_d;
            tag_id_q   <= tag_id_d;
            cnt_q      <= cnt_d;
            err_q      <= err_d;
        end
    end

    assign fpu_opA_o    = opa_q;
    assign fpu_opB_o    = opb_q;
    assign fpu_op_o     = op_q;
    assign fpu_status_o = status_q;
    assign rsp_valid_o  = tag_vld_q[PIPELINE_DEPTH-1];
    assign rsp_id_o     = tag_id_q[PIPELINE_DEPTH-1];
    assign rsp_result_o = fpu_result_i;
    assign idle_o       = (state_q == ST_IDLE) && !inflight;
    assign err_o        = err_q;

endmodule
